alu_seq_ctrl: RTL

- Sequences the team's 8-bit combinational ALU (NOP/ADD/SUB/AND/NOT) around an internal 8-bit accumulator.
- Accepts one command per valid/ready handshake, drives the ALU's A/B/CNTL inputs and captures its result and flags.
- Builds multi-cycle multiply from repeated ADDs.
- Sits between the microcontroller's instruction decode and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences the 8-bit ALU around an accumulator.
// Optional macro ALU_SEQ_MUL_EN enables multi-cycle MUL.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] CMD,
  input  logic [7:0] OPND,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] CNTL,
  input  logic [7:0] Y,
  input  logic       alu_ovr,
  input  logic       alu_neg,
  output logic [7:0] ACC,
  output logic       zero,
  output logic       ovr,
  output logic       neg,
  output logic       err,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] C_LOAD = 3'b000;
  localparam logic [2:0] C_ADD  = 3'b001;
  localparam logic [2:0] C_SUB  = 3'b010;
  localparam logic [2:0] C_AND  = 3'b011;
  localparam logic [2:0] C_NOT  = 3'b100;
  localparam logic [2:0] C_MUL  = 3'b101;
  localparam logic [2:0] C_CLR  = 3'b110;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] cmd_q;
  logic [7:0] opnd_q;
  logic       legal;

`ifdef ALU_SEQ_MUL_EN
  logic [7:0] cnt;
  logic       sticky;
  assign legal = (CMD != 3'b111);
`else
  assign legal = (CMD != 3'b111) && (CMD != C_MUL);
`endif

  // Handshake, operand staging, result capture and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= C_LOAD;
      opnd_q    <= '0;
      A         <= '0;
      B         <= '0;
      CNTL      <= OP_NOP;
      ACC       <= '0;
      zero      <= 1'b0;
      ovr       <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      cnt       <= '0;
      sticky    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q     <= CMD;
            opnd_q    <= OPND;
            state     <= EXEC;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (legal) err <= 1'b0;
            A    <= '0;
            B    <= '0;
            CNTL <= OP_NOP;
            case (CMD)
              C_ADD, C_SUB, C_AND: begin
                A    <= ACC;
                B    <= OPND;
                CNTL <= CMD;
              end
              C_NOT: begin
                A    <= ACC;
                CNTL <= OP_NOT;
              end
`ifdef ALU_SEQ_MUL_EN
              C_MUL: begin
                B      <= ACC;
                cnt    <= OPND;
                sticky <= 1'b0;
                CNTL   <= (OPND == 8'd0) ? OP_NOP
                                         : OP_ADD;
              end
`endif
              default: ;
            endcase
          end
        end
        EXEC: begin
          state <= DONE;
          done  <= 1'b1;
          CNTL  <= OP_NOP;
          case (cmd_q)
            C_ADD: begin
              ACC  <= Y;
              zero <= (Y == 8'd0);
              ovr  <= alu_ovr;
              neg  <= 1'b0;
            end
            C_SUB: begin
              ACC  <= Y;
              zero <= (Y == 8'd0);
              ovr  <= 1'b0;
              neg  <= alu_neg;
            end
            C_AND, C_NOT: begin
              ACC  <= Y;
              zero <= (Y == 8'd0);
              ovr  <= 1'b0;
              neg  <= 1'b0;
            end
            C_LOAD: begin
              ACC  <= opnd_q;
              zero <= (opnd_q == 8'd0);
              ovr  <= 1'b0;
              neg  <= 1'b0;
            end
            C_CLR: begin
              ACC  <= '0;
              zero <= 1'b1;
              ovr  <= 1'b0;
              neg  <= 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            C_MUL: begin
              neg <= 1'b0;
              if (cnt == 8'd0) begin
                ACC  <= '0;
                zero <= 1'b1;
                ovr  <= 1'b0;
              end else begin
                A      <= Y;
                sticky <= sticky | alu_ovr;
                cnt    <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                  ACC  <= Y;
                  zero <= (Y == 8'd0);
                  ovr  <= sticky | alu_ovr;
                end else begin
                  state <= EXEC;
                  done  <= 1'b0;
                  CNTL  <= OP_ADD;
                end
              end
            end
`endif
            default: err <= 1'b1;
          endcase
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
